// File: rtl/div_timer_multi.sv
// System DIV counter plus NCH TIMA-style timer channels on the CPU register bus.
// Each channel counts falling edges of a selectable DIV tap and reloads from MOD on overflow.
module div_timer_multi #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TAP0  = 9,
  parameter int unsigned TAP1  = 3,
  parameter int unsigned TAP2  = 5,
  parameter int unsigned TAP3  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  input  logic [3:0]       addr,
  input  logic [7:0]       d_in,
  output logic [7:0]       d_out,
  output logic [DIV_W-1:0] div_q,
  output logic [NCH-1:0]   irq
);

  localparam logic [0:0]       ST_RUN  = 1'b0;
  localparam logic [0:0]       ST_OVF  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic div_wr;
  assign div_wr = cpu_wr && (addr == 4'd0);

  // Free-running divider; a CPU write clears it and wins over the tick
  always_ff @(posedge clk) begin
    if (reset)        div_q <= '0;
    else if (div_wr)  div_q <= '0;
    else if (tick_en) div_q <= div_q + DIV_W'(1);
  end

  logic [CNT_W-1:0] cnt_a  [NCH];
  logic [CNT_W-1:0] mod_a  [NCH];
  logic [2:0]       ctrl_a [NCH];

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    localparam logic [3:0] A_CNT  = 4'(1 + 3 * ch);
    localparam logic [3:0] A_MOD  = 4'(2 + 3 * ch);
    localparam logic [3:0] A_CTRL = 4'(3 + 3 * ch);

    logic [CNT_W-1:0] cnt, cnt_nxt, mod_r;
    logic [0:0]       state, state_nxt;
    logic [1:0]       sel;
    logic             en, tap, t, t_prev, inc, irq_r, irq_nxt;
    logic             wr_cnt, wr_mod, wr_ctrl;

    assign wr_cnt  = cpu_wr && (addr == A_CNT);
    assign wr_mod  = cpu_wr && (addr == A_MOD);
    assign wr_ctrl = cpu_wr && (addr == A_CTRL);

    always_comb begin
      tap = 1'b0;
      case (sel)
        2'd0:    tap = div_q[TAP0];
        2'd1:    tap = div_q[TAP1];
        2'd2:    tap = div_q[TAP2];
        default: tap = div_q[TAP3];
      endcase
    end

    // Any 1->0 on the gated tap counts, including ones caused by en/sel/DIV writes
    assign t   = en & tap;
    assign inc = t_prev & ~t;

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      irq_nxt   = 1'b0;
      case (state)
        ST_RUN: begin
          if (wr_cnt) begin
            cnt_nxt = d_in[CNT_W-1:0];
          end else if (inc) begin
            if (cnt == CNT_MAX) begin
              cnt_nxt   = '0;
              state_nxt = ST_OVF;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        ST_OVF: begin
          state_nxt = ST_RUN;
          if (wr_cnt) begin
            cnt_nxt = d_in[CNT_W-1:0];
          end else begin
            cnt_nxt = wr_mod ? d_in[CNT_W-1:0] : mod_r;
            irq_nxt = 1'b1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= ST_RUN;
        cnt    <= '0;
        mod_r  <= '0;
        en     <= 1'b0;
        sel    <= 2'd0;
        t_prev <= 1'b0;
        irq_r  <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        t_prev <= t;
        irq_r  <= irq_nxt;
        if (wr_mod) mod_r <= d_in[CNT_W-1:0];
        if (wr_ctrl) begin
          en  <= d_in[2];
          sel <= d_in[1:0];
        end
      end
    end

    assign irq[ch]    = irq_r;
    assign cnt_a[ch]  = cnt;
    assign mod_a[ch]  = mod_r;
    assign ctrl_a[ch] = {en, sel};
  end

  // Combinational register read mux
  always_comb begin
    d_out = 8'hFF;
    if (cpu_rd) begin
      if (addr == 4'd0) d_out = div_q[DIV_W-1 -: 8];
      for (int i = 0; i < NCH; i++) begin
        if (addr == 4'(1 + 3 * i)) d_out = 8'(cnt_a[i]);
        if (addr == 4'(2 + 3 * i)) d_out = 8'(mod_a[i]);
        if (addr == 4'(3 + 3 * i)) d_out = {5'b11111, ctrl_a[i]};
      end
    end
  end

endmodule

// File: tb/tb_div_timer_multi.sv
// Directed self-checking bench for div_timer_multi (DIV_W=16, NCH=2, CNT_W=8).
module tb_div_timer_multi;

  logic        clk = 1'b0;
  logic        reset, tick_en, cpu_wr, cpu_rd;
  logic [3:0]  addr;
  logic [7:0]  d_in, d_out;
  logic [15:0] div_q;
  logic [1:0]  irq;

  int passed = 0;
  int total  = 0;

  div_timer_multi dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .addr(addr), .d_in(d_in), .d_out(d_out), .div_q(div_q), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick_en = 1'b1;
    for (int i = 0; i < n; i++) step();
    tick_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cpu_wr = 1'b1; addr = a; d_in = d;
    step();
    cpu_wr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] v;
    addr = a; cpu_rd = 1'b1;
    #1;
    v = d_out;
    cpu_rd = 1'b0;
    chk(tag, 32'(v), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; tick_en = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; addr = '0; d_in = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_div", 32'(div_q), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk_rd("rst_cnt0", 4'd1, 8'h00);
    chk_rd("rst_ctrl0", 4'd3, 8'hF8);
    addr = 4'd0; #1;
    chk("rd_idle_ff", 32'(d_out), 32'hFF);

    // 1: DIV counts 256 ticks
    ticks(256);
    chk("div_256", 32'(div_q), 32'h100);
    chk_rd("div_rd_01", 4'd0, 8'h01);

    // 2: CH0 overflow and reload
    wr(4'd0, 8'h00);
    wr(4'd3, 8'h05);
    wr(4'd2, 8'hFE);
    wr(4'd1, 8'hFF);
    chk_rd("ctrl0_rd", 4'd3, 8'hFD);
    ticks(16);
    chk_rd("t2_pre_fall", 4'd1, 8'hFF);
    step();
    chk_rd("t2_cnt_zero", 4'd1, 8'h00);
    chk("t2_irq_ovf", 32'(irq), 32'h0);
    step();
    chk_rd("t2_reload", 4'd1, 8'hFE);
    chk("t2_irq_pulse", 32'(irq), 32'h1);
    step();
    chk("t2_irq_end", 32'(irq), 32'h0);
    chk_rd("t2_cnt_hold", 4'd1, 8'hFE);

    // 3: CNT write during OVF cancels reload and irq
    wr(4'd0, 8'h00);
    wr(4'd1, 8'hFF);
    ticks(16);
    step();
    chk_rd("t3_cnt_zero", 4'd1, 8'h00);
    wr(4'd1, 8'h42);
    chk_rd("t3_cnt_42", 4'd1, 8'h42);
    chk("t3_no_irq_a", 32'(irq), 32'h0);
    step();
    chk("t3_no_irq_b", 32'(irq), 32'h0);
    chk_rd("t3_cnt_hold", 4'd1, 8'h42);

    // 4: MOD write during OVF feeds the reload
    wr(4'd0, 8'h00);
    wr(4'd1, 8'hFF);
    ticks(16);
    step();
    chk_rd("t4_cnt_zero", 4'd1, 8'h00);
    wr(4'd2, 8'h10);
    chk_rd("t4_cnt_10", 4'd1, 8'h10);
    chk("t4_irq_pulse", 32'(irq), 32'h1);
    step();
    chk("t4_irq_end", 32'(irq), 32'h0);
    chk_rd("t4_mod_rd", 4'd2, 8'h10);

    // 5: DIV write drops bit9 on CH1 -> exactly one increment
    wr(4'd3, 8'h00);
    wr(4'd4, 8'h20);
    wr(4'd0, 8'h00);
    wr(4'd6, 8'h04);
    ticks(512);
    chk("t5_div_512", 32'(div_q), 32'h200);
    tick_en = 1'b1;
    wr(4'd0, 8'h5A);
    tick_en = 1'b0;
    chk("t5_div_clr", 32'(div_q), 32'h0);
    chk_rd("t5_cnt1_pre", 4'd4, 8'h20);
    step();
    chk_rd("t5_cnt1_inc", 4'd4, 8'h21);
    step();
    chk_rd("t5_cnt1_once", 4'd4, 8'h21);
    chk("t5_div_zero", 32'(div_q), 32'h0);

    // 6: Reset while CH0 is in OVF
    wr(4'd3, 8'h05);
    wr(4'd2, 8'hFE);
    wr(4'd1, 8'hFF);
    ticks(16);
    step();
    chk_rd("t6_cnt_zero", 4'd1, 8'h00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_irq_a", 32'(irq), 32'h0);
    chk_rd("t6_cnt0", 4'd1, 8'h00);
    chk_rd("t6_mod0", 4'd2, 8'h00);
    chk_rd("t6_addr13", 4'd13, 8'hFF);
    step();
    chk("t6_irq_b", 32'(irq), 32'h0);
    chk_rd("t6_cnt0_hold", 4'd1, 8'h00);
    chk_rd("t6_ctrl0", 4'd3, 8'hF8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
